// File: rtl/ex_operand_stage_pkg.sv
// Shared types for the ID/EX operand stage: operand-select encoding, ALU opcodes, registered bundle.
// Forwarding is compiled in only when EX_OPERAND_FWD_EN is defined (see fwd_mux / ex_operand_stage).
package ex_pkg;

    localparam int EX_XLEN   = 32;
    localparam int EX_REG_AW = 4;

    typedef enum logic [1:0] {
        SRC1_RS1  = 2'b00,
        SRC1_PC   = 2'b01,
        SRC1_ZERO = 2'b10
    } src1_sel_e;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_PASS2 = 4'b1000;

    typedef struct packed {
        logic                 valid;
        logic [3:0]           alu_ctrl;
        logic [EX_XLEN-1:0]   data1;
        logic [EX_XLEN-1:0]   data2;
        logic [EX_XLEN-1:0]   store_data;
        logic [EX_XLEN-1:0]   pc;
        logic [EX_REG_AW-1:0] rd_addr;
        logic                 reg_write;
    } ex_bundle_t;

endpackage

// File: rtl/ex_operand_stage_if.sv
// Decode-side, forwarding-source and ALU-side signals of the ID/EX operand stage.
// master = surrounding pipeline (decode, EX/MEM, MEM/WB, ALU); slave = the stage itself.
interface ex_operand_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 4
);
    logic              flush;
    logic              id_valid;
    logic              id_ready;
    logic [XLEN-1:0]   id_pc;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [REG_AW-1:0] id_rs1_addr;
    logic [REG_AW-1:0] id_rs2_addr;
    logic              id_rs1_use;
    logic              id_rs2_use;
    logic [REG_AW-1:0] id_rd_addr;
    logic              id_reg_write;
    logic [XLEN-1:0]   id_imm;
    logic [3:0]        id_alu_ctrl;
    logic [1:0]        id_src1_sel;
    logic              id_src2_sel;
    logic              exm_valid;
    logic              exm_reg_write;
    logic              exm_is_load;
    logic [REG_AW-1:0] exm_rd_addr;
    logic [XLEN-1:0]   exm_data;
    logic              wb_valid;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_rd_addr;
    logic [XLEN-1:0]   wb_data;
    logic              ex_valid;
    logic              ex_ready;
    logic [3:0]        ex_alu_ctrl;
    logic [XLEN-1:0]   ex_data1;
    logic [XLEN-1:0]   ex_data2;
    logic [XLEN-1:0]   ex_store_data;
    logic [XLEN-1:0]   ex_pc;
    logic [REG_AW-1:0] ex_rd_addr;
    logic              ex_reg_write;

    modport master (
        output flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_rs1_addr, id_rs2_addr,
               id_rs1_use, id_rs2_use, id_rd_addr, id_reg_write, id_imm, id_alu_ctrl,
               id_src1_sel, id_src2_sel,
               exm_valid, exm_reg_write, exm_is_load, exm_rd_addr, exm_data,
               wb_valid, wb_reg_write, wb_rd_addr, wb_data, ex_ready,
        input  id_ready, ex_valid, ex_alu_ctrl, ex_data1, ex_data2, ex_store_data, ex_pc,
               ex_rd_addr, ex_reg_write
    );

    modport slave (
        input  flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_rs1_addr, id_rs2_addr,
               id_rs1_use, id_rs2_use, id_rd_addr, id_reg_write, id_imm, id_alu_ctrl,
               id_src1_sel, id_src2_sel,
               exm_valid, exm_reg_write, exm_is_load, exm_rd_addr, exm_data,
               wb_valid, wb_reg_write, wb_rd_addr, wb_data, ex_ready,
        output id_ready, ex_valid, ex_alu_ctrl, ex_data1, ex_data2, ex_store_data, ex_pc,
               ex_rd_addr, ex_reg_write
    );
endinterface

// File: rtl/ex_operand_stage_fwd_mux.sv
// Per-source RAW resolution: picks EX/MEM, MEM/WB or regfile value and flags a stall.
// EX_OPERAND_FWD_EN selects forwarding; otherwise every in-flight producer stalls the consumer.
module fwd_mux #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 4
) (
    input  logic [REG_AW-1:0] rs_addr,
    input  logic              rs_use,
    input  logic [XLEN-1:0]   rf_data,
    input  logic              exm_valid,
    input  logic              exm_reg_write,
    input  logic              exm_is_load,
    input  logic [REG_AW-1:0] exm_rd_addr,
    input  logic [XLEN-1:0]   exm_data,
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   fwd_data,
    output logic              hazard
);
    logic rs_nz;
    logic exm_match;
    logic wb_match;

    // x0 is hard-wired zero, so a producer "writing" x0 never creates a dependency
    assign rs_nz     = (rs_addr != '0);
    assign exm_match = rs_nz & exm_valid & exm_reg_write & (exm_rd_addr == rs_addr);
    assign wb_match  = rs_nz & wb_valid & wb_reg_write & (wb_rd_addr == rs_addr);

`ifdef EX_OPERAND_FWD_EN
    logic exm_hit;

    assign exm_hit  = exm_match & ~exm_is_load;
    assign fwd_data = exm_hit ? exm_data : (wb_match ? wb_data : rf_data);
    assign hazard   = rs_use & exm_match & exm_is_load;
`else
    logic unused_fwd_inputs;

    assign unused_fwd_inputs = ^{exm_data, wb_data, exm_is_load};
    assign fwd_data          = rf_data;
    assign hazard            = rs_use & (exm_match | wb_match);
`endif

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register ahead of the ALU: hazard stall, operand select, 1-entry valid/ready stage.
// Build option EX_OPERAND_FWD_EN enables EX/MEM and MEM/WB forwarding in fwd_mux.
module ex_operand_stage
    import ex_pkg::*;
#(
    parameter int XLEN   = EX_XLEN,
    parameter int REG_AW = EX_REG_AW
) (
    input logic               clk,
    input logic               rst,
    ex_operand_stage_if.slave bus
);
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic            rs1_hazard;
    logic            rs2_hazard;
    logic            hazard;
    logic            fire;
    ex_bundle_t      ex_q;
    ex_bundle_t      ex_d;

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs_addr       (bus.id_rs1_addr),
        .rs_use        (bus.id_rs1_use),
        .rf_data       (bus.id_rs1_data),
        .exm_valid     (bus.exm_valid),
        .exm_reg_write (bus.exm_reg_write),
        .exm_is_load   (bus.exm_is_load),
        .exm_rd_addr   (bus.exm_rd_addr),
        .exm_data      (bus.exm_data),
        .wb_valid      (bus.wb_valid),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_rd_addr    (bus.wb_rd_addr),
        .wb_data       (bus.wb_data),
        .fwd_data      (rs1_fwd),
        .hazard        (rs1_hazard)
    );

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs_addr       (bus.id_rs2_addr),
        .rs_use        (bus.id_rs2_use),
        .rf_data       (bus.id_rs2_data),
        .exm_valid     (bus.exm_valid),
        .exm_reg_write (bus.exm_reg_write),
        .exm_is_load   (bus.exm_is_load),
        .exm_rd_addr   (bus.exm_rd_addr),
        .exm_data      (bus.exm_data),
        .wb_valid      (bus.wb_valid),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_rd_addr    (bus.wb_rd_addr),
        .wb_data       (bus.wb_data),
        .fwd_data      (rs2_fwd),
        .hazard        (rs2_hazard)
    );

    assign hazard       = rs1_hazard | rs2_hazard;
    assign bus.id_ready = (~ex_q.valid | bus.ex_ready) & ~hazard & ~bus.flush;
    assign fire         = bus.id_valid & bus.id_ready;

    always_comb begin
        ex_d            = '0;
        ex_d.valid      = 1'b1;
        ex_d.alu_ctrl   = bus.id_alu_ctrl;
        ex_d.pc         = bus.id_pc;
        ex_d.rd_addr    = bus.id_rd_addr;
        ex_d.reg_write  = bus.id_reg_write;
        ex_d.store_data = rs2_fwd;
        ex_d.data2      = bus.id_src2_sel ? bus.id_imm : rs2_fwd;
        // the reserved src1 encoding reads as zero, same as SRC1_ZERO
        case (bus.id_src1_sel)
            SRC1_RS1: ex_d.data1 = rs1_fwd;
            SRC1_PC:  ex_d.data1 = bus.id_pc;
            default:  ex_d.data1 = '0;
        endcase
    end

    // flush beats fire and hold; a drained slot with nothing new becomes a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else if (bus.flush) begin
            ex_q.valid     <= 1'b0;
            ex_q.reg_write <= 1'b0;
        end else if (fire) begin
            ex_q <= ex_d;
        end else if (bus.ex_ready) begin
            ex_q.valid     <= 1'b0;
            ex_q.reg_write <= 1'b0;
        end
    end

    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_alu_ctrl   = ex_q.alu_ctrl;
    assign bus.ex_data1      = ex_q.data1;
    assign bus.ex_data2      = ex_q.data2;
    assign bus.ex_store_data = ex_q.store_data;
    assign bus.ex_pc         = ex_q.pc;
    assign bus.ex_rd_addr    = ex_q.rd_addr;
    assign bus.ex_reg_write  = ex_q.reg_write;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: vector table plus reset/load-use/backpressure/flush sequences.
// Expected values follow the EX_OPERAND_FWD_EN setting of the build.
module tb_ex_operand_stage;
    import ex_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ex_operand_stage_if #(.XLEN(32), .REG_AW(4)) bus ();

    ex_operand_stage #(.XLEN(32), .REG_AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  rs1, rs2;
        logic [31:0] rf1, rf2;
        logic        u1, u2;
        logic [1:0]  s1;
        logic        s2;
        logic [31:0] imm, pc;
        logic [3:0]  alu, rd;
        logic        rw;
        logic        ev, ew, el;
        logic [3:0]  erd;
        logic [31:0] edata;
        logic        wv, ww;
        logic [3:0]  wrd;
        logic [31:0] wdata;
        logic        x_ready;
        logic [31:0] x_d1, x_d2, x_st;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];
    vec_t vz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.flush = 0; bus.id_valid = 0; bus.id_pc = '0;
        bus.id_rs1_data = '0; bus.id_rs2_data = '0; bus.id_rs1_addr = '0; bus.id_rs2_addr = '0;
        bus.id_rs1_use = 0; bus.id_rs2_use = 0; bus.id_rd_addr = '0; bus.id_reg_write = 0;
        bus.id_imm = '0; bus.id_alu_ctrl = '0; bus.id_src1_sel = '0; bus.id_src2_sel = 0;
        bus.exm_valid = 0; bus.exm_reg_write = 0; bus.exm_is_load = 0; bus.exm_rd_addr = '0;
        bus.exm_data = '0; bus.wb_valid = 0; bus.wb_reg_write = 0; bus.wb_rd_addr = '0;
        bus.wb_data = '0; bus.ex_ready = 1;
    endtask

    task automatic drive(input vec_t v);
        bus.id_valid = 1; bus.flush = 0; bus.ex_ready = 1;
        bus.id_rs1_addr = v.rs1; bus.id_rs2_addr = v.rs2;
        bus.id_rs1_data = v.rf1; bus.id_rs2_data = v.rf2;
        bus.id_rs1_use = v.u1; bus.id_rs2_use = v.u2;
        bus.id_src1_sel = v.s1; bus.id_src2_sel = v.s2;
        bus.id_imm = v.imm; bus.id_pc = v.pc; bus.id_alu_ctrl = v.alu;
        bus.id_rd_addr = v.rd; bus.id_reg_write = v.rw;
        bus.exm_valid = v.ev; bus.exm_reg_write = v.ew; bus.exm_is_load = v.el;
        bus.exm_rd_addr = v.erd; bus.exm_data = v.edata;
        bus.wb_valid = v.wv; bus.wb_reg_write = v.ww; bus.wb_rd_addr = v.wrd; bus.wb_data = v.wdata;
    endtask

    task automatic apply_vec(input vec_t v, input int i);
        @(negedge clk);
        drive(v);
        #1 chk($sformatf("v%0d id_ready", i), 32'(bus.id_ready), 32'(v.x_ready));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d ex_valid", i), 32'(bus.ex_valid), 32'(v.x_ready));
        if (v.x_ready) begin
            chk($sformatf("v%0d data1", i), bus.ex_data1, v.x_d1);
            chk($sformatf("v%0d data2", i), bus.ex_data2, v.x_d2);
            chk($sformatf("v%0d store", i), bus.ex_store_data, v.x_st);
            chk($sformatf("v%0d pc", i), bus.ex_pc, v.pc);
            chk($sformatf("v%0d alu", i), 32'(bus.ex_alu_ctrl), 32'(v.alu));
            chk($sformatf("v%0d rd", i), 32'(bus.ex_rd_addr), 32'(v.rd));
            chk($sformatf("v%0d rw", i), 32'(bus.ex_reg_write), 32'(v.rw));
        end else begin
            chk($sformatf("v%0d rw bubble", i), 32'(bus.ex_reg_write), 32'd0);
        end
    endtask

    initial begin
        vec_t v;
`ifdef EX_OPERAND_FWD_EN
        bit fwd = 1'b1;
`else
        bit fwd = 1'b0;
`endif
        vz = '{default: '0};

        // plain ADD, no producers in flight
        v = vz; v.rs1 = 1; v.rf1 = 32'h100; v.rs2 = 2; v.rf2 = 32'h200; v.u1 = 1; v.u2 = 1;
        v.alu = ALU_ADD; v.rd = 3; v.rw = 1; v.pc = 32'h1000;
        v.x_ready = 1; v.x_d1 = 32'h100; v.x_d2 = 32'h200; v.x_st = 32'h200; vecs[0] = v;
        // EX/MEM and MEM/WB both write x5: EX/MEM wins
        v = vz; v.rs1 = 5; v.rf1 = 32'h99; v.u1 = 1; v.rs2 = 6; v.rf2 = 32'h66; v.s2 = 1; v.imm = 4;
        v.alu = ALU_ADD; v.rd = 7; v.rw = 1; v.pc = 32'h1004;
        v.ev = 1; v.ew = 1; v.erd = 5; v.edata = 32'h11; v.wv = 1; v.ww = 1; v.wrd = 5; v.wdata = 32'h22;
        v.x_ready = fwd; v.x_d1 = 32'h11; v.x_d2 = 4; v.x_st = 32'h66; vecs[1] = v;
        // only MEM/WB matches
        v = vz; v.rs1 = 5; v.rf1 = 32'h99; v.u1 = 1; v.rs2 = 6; v.rf2 = 32'h66; v.u2 = 1;
        v.alu = ALU_SUB; v.rd = 8; v.rw = 1; v.pc = 32'h1008;
        v.ev = 1; v.ew = 1; v.erd = 7; v.edata = 32'h11; v.wv = 1; v.ww = 1; v.wrd = 5; v.wdata = 32'h22;
        v.x_ready = fwd; v.x_d1 = 32'h22; v.x_d2 = 32'h66; v.x_st = 32'h66; vecs[2] = v;
        // x0 sources are never forwarded nor stalled on
        v = vz; v.u1 = 1; v.u2 = 1; v.alu = ALU_ADD; v.pc = 32'h100c;
        v.ev = 1; v.ew = 1; v.erd = 0; v.edata = 32'h11; v.wv = 1; v.ww = 1; v.wrd = 0; v.wdata = 32'h22;
        v.x_ready = 1; v.x_d1 = 0; v.x_d2 = 0; v.x_st = 0; vecs[3] = v;
        // LUI
        v = vz; v.s1 = 2'b10; v.s2 = 1; v.imm = 32'h12345000; v.rf1 = 32'hdead; v.alu = ALU_PASS2;
        v.rd = 4; v.rw = 1; v.pc = 32'h1010;
        v.x_ready = 1; v.x_d1 = 0; v.x_d2 = 32'h12345000; v.x_st = 0; vecs[4] = v;
        // AUIPC
        v = vz; v.s1 = 2'b01; v.s2 = 1; v.imm = 32'h1000; v.alu = ALU_ADD; v.rd = 5; v.rw = 1; v.pc = 32'h2000;
        v.x_ready = 1; v.x_d1 = 32'h2000; v.x_d2 = 32'h1000; v.x_st = 0; vecs[5] = v;
        // reserved src1 encoding reads zero
        v = vz; v.s1 = 2'b11; v.rs1 = 1; v.rf1 = 32'hdead; v.rs2 = 2; v.rf2 = 32'h5; v.alu = ALU_OR;
        v.rd = 6; v.rw = 0; v.pc = 32'h2004;
        v.x_ready = 1; v.x_d1 = 0; v.x_d2 = 32'h5; v.x_st = 32'h5; vecs[6] = v;
        // store data forwarded while data2 is the immediate
        v = vz; v.rs1 = 1; v.rf1 = 32'h300; v.rs2 = 9; v.rf2 = 32'h9; v.u1 = 1; v.u2 = 1; v.s2 = 1;
        v.imm = 8; v.alu = ALU_ADD; v.pc = 32'h2008; v.wv = 1; v.ww = 1; v.wrd = 9; v.wdata = 32'h77;
        v.x_ready = fwd; v.x_d1 = 32'h300; v.x_d2 = 8; v.x_st = 32'h77; vecs[7] = v;
        // load in EX/MEM to a source the instr does not use: no stall, not forwarded
        v = vz; v.rs1 = 4; v.rf1 = 32'h44; v.u1 = 0; v.alu = ALU_AND; v.rd = 2; v.rw = 1; v.pc = 32'h200c;
        v.ev = 1; v.ew = 1; v.el = 1; v.erd = 4; v.edata = 32'hbad;
        v.x_ready = 1; v.x_d1 = 32'h44; v.x_d2 = 0; v.x_st = 0; vecs[8] = v;
        // EX/MEM matches but does not write: MEM/WB supplies
        v = vz; v.rs1 = 5; v.rf1 = 32'h99; v.u1 = 1; v.alu = ALU_SLT; v.rd = 3; v.rw = 1; v.pc = 32'h2010;
        v.ev = 1; v.ew = 0; v.erd = 5; v.edata = 32'h11; v.wv = 1; v.ww = 1; v.wrd = 5; v.wdata = 32'h22;
        v.x_ready = fwd; v.x_d1 = 32'h22; v.x_d2 = 0; v.x_st = 0; vecs[9] = v;

        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset ex_valid", 32'(bus.ex_valid), 0);
        chk("reset ex_data1", bus.ex_data1, 0);
        chk("reset ex_reg_write", 32'(bus.ex_reg_write), 0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < NV; i++) apply_vec(vecs[i], i);

        // load-use on rs2: one stall, then value via MEM/WB
        @(negedge clk);
        v = vz; v.rs2 = 3; v.rf2 = 32'h3; v.u2 = 1; v.rs1 = 1; v.rf1 = 32'h1; v.u1 = 1;
        v.alu = ALU_ADD; v.rd = 6; v.rw = 1; v.pc = 32'h3000;
        v.ev = 1; v.ew = 1; v.el = 1; v.erd = 3; v.edata = 32'hbad;
        drive(v);
        #1 chk("ldu stall ready", 32'(bus.id_ready), 0);
        @(posedge clk); #1;
        chk("ldu bubble", 32'(bus.ex_valid), 0);
        @(negedge clk);
        bus.exm_valid = 0; bus.exm_is_load = 0;
        bus.wb_valid = 1; bus.wb_reg_write = 1; bus.wb_rd_addr = 3; bus.wb_data = 32'h33;
`ifndef EX_OPERAND_FWD_EN
        #1 chk("ldu wb stall ready", 32'(bus.id_ready), 0);
        @(posedge clk); #1;
        chk("ldu wb bubble", 32'(bus.ex_valid), 0);
        @(negedge clk);
        bus.wb_valid = 0; bus.id_rs2_data = 32'h33;
`endif
        #1 chk("ldu retry ready", 32'(bus.id_ready), 1);
        @(posedge clk); #1;
        chk("ldu retry valid", 32'(bus.ex_valid), 1);
        chk("ldu retry data2", bus.ex_data2, 32'h33);
        chk("ldu retry store", bus.ex_store_data, 32'h33);

        // backpressure: B held off three cycles, A stays put
        @(negedge clk);
        idle(); bus.id_valid = 1; bus.id_pc = 32'h10; bus.id_rd_addr = 1; bus.id_reg_write = 1;
        @(posedge clk); #1;
        chk("bp A pc", bus.ex_pc, 32'h10);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.ex_ready = 0; bus.id_pc = 32'h14; bus.id_rd_addr = 2;
            #1 chk($sformatf("bp hold%0d ready", k), 32'(bus.id_ready), 0);
            @(posedge clk); #1;
            chk($sformatf("bp hold%0d pc", k), bus.ex_pc, 32'h10);
            chk($sformatf("bp hold%0d rd", k), 32'(bus.ex_rd_addr), 1);
            chk($sformatf("bp hold%0d valid", k), 32'(bus.ex_valid), 1);
        end
        @(negedge clk);
        bus.ex_ready = 1;
        #1 chk("bp resume ready", 32'(bus.id_ready), 1);
        @(posedge clk); #1;
        chk("bp B pc", bus.ex_pc, 32'h14);
        chk("bp B rd", 32'(bus.ex_rd_addr), 2);

        // flush with a valid stage and a valid incoming instr
        @(negedge clk);
        bus.id_pc = 32'h18; bus.flush = 1;
        #1 chk("flush ready", 32'(bus.id_ready), 0);
        @(posedge clk); #1;
        chk("flush ex_valid", 32'(bus.ex_valid), 0);
        chk("flush ex_reg_write", 32'(bus.ex_reg_write), 0);
        @(negedge clk);
        bus.flush = 0; bus.id_valid = 0;
        @(posedge clk); #1;
        chk("flush no replay", 32'(bus.ex_valid), 0);

        // synchronous reset in the middle of traffic
        @(negedge clk);
        idle(); bus.id_valid = 1; bus.id_pc = 32'habc; bus.id_imm = 32'h7; bus.id_src2_sel = 1;
        bus.id_rd_addr = 9; bus.id_reg_write = 1; bus.id_alu_ctrl = ALU_ADD;
        @(posedge clk); #1;
        chk("rst pre valid", 32'(bus.ex_valid), 1);
        @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        chk("rst mid valid", 32'(bus.ex_valid), 0);
        chk("rst mid pc", bus.ex_pc, 0);
        chk("rst mid data2", bus.ex_data2, 0);
        chk("rst mid rd", 32'(bus.ex_rd_addr), 0);
        chk("rst mid rw", 32'(bus.ex_reg_write), 0);
        chk("rst mid alu", 32'(bus.ex_alu_ctrl), 0);
        @(negedge clk);
        rst = 0; bus.id_pc = 32'h5550;
        @(posedge clk); #1;
        chk("rst post valid", 32'(bus.ex_valid), 1);
        chk("rst post pc", bus.ex_pc, 32'h5550);
        @(negedge clk);
        idle();
        @(posedge clk); #1;
        chk("final bubble", 32'(bus.ex_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
